// File: rtl/add_seq_ctrl.sv
// Multi-cycle adder: sums two WIDTH-bit operands through one 2-bit slice per cycle,
// with a registered carry between slices and a start/busy/done handshake.
module add_seq_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] s_o,
    output logic             co_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int unsigned N    = WIDTH / 2;
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_q;
    logic             c_q;
    logic             co_q;
    logic             busy_q;
    logic             done_q;
    logic [IdxW-1:0]  idx_q;

    logic [IdxW:0]    lsb;
    logic [1:0]       a_sl;
    logic [1:0]       b_sl;
    logic [2:0]       slice_sum;

    // Current slice: bits [2*idx+1 : 2*idx], carry-in from the previous slice.
    always_comb begin
        lsb       = {idx_q, 1'b0};
        a_sl      = a_q[lsb +: 2];
        b_sl      = b_q[lsb +: 2];
        slice_sum = {1'b0, a_sl} + {1'b0, b_sl} + {2'b00, c_q};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            co_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start_i) begin
                        state_q <= StRun;
                        a_q     <= a_i;
                        b_q     <= b_i;
                        s_q     <= '0;
                        c_q     <= 1'b0;
                        co_q    <= 1'b0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end else begin
                        state_q <= StIdle;
                        done_q  <= 1'b0;
                    end
                end
                StRun: begin
                    s_q[lsb +: 2] <= slice_sum[1:0];
                    c_q           <= slice_sum[2];
                    idx_q         <= idx_q + IdxW'(1);
                    if (idx_q == LastIdx) begin
                        co_q    <= slice_sum[2];
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign s_o    = s_q;
    assign co_o   = co_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed bench for add_seq_ctrl: an 8-bit and a 2-bit instance on a shared clock.
module tb_add_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic [7:0] s8;
    logic       co8;
    logic       busy8;
    logic       done8;
    logic       start2;
    logic [1:0] a2;
    logic [1:0] b2;
    logic [1:0] s2;
    logic       co2;
    logic       busy2;
    logic       done2;

    int checks = 0;
    int errors = 0;

    add_seq_ctrl #(.WIDTH(8)) dut8 (
        .clk_i  (clk),
        .rst_i  (rst),
        .start_i(start8),
        .a_i    (a8),
        .b_i    (b8),
        .s_o    (s8),
        .co_o   (co8),
        .busy_o (busy8),
        .done_o (done8)
    );

    add_seq_ctrl #(.WIDTH(2)) dut2 (
        .clk_i  (clk),
        .rst_i  (rst),
        .start_i(start2),
        .a_i    (a2),
        .b_i    (b2),
        .s_o    (s2),
        .co_o   (co2),
        .busy_o (busy2),
        .done_o (done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called right after the accepting edge; returns busy samples and edges until done.
    task automatic wait_done8(output int nbusy, output int nsteps);
        nbusy  = 0;
        nsteps = 0;
        while (!done8 && nsteps < 20) begin
            if (busy8) nbusy++;
            chk("busy8_done8_excl", 32'(busy8 & done8), 0);
            step();
            nsteps++;
        end
        chk("done8_seen", 32'(done8), 1);
        chk("busy8_at_done", 32'(busy8), 0);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input string tag,
                       input logic [7:0] exp_s, input logic exp_co);
        int nb;
        int ns;
        a8     = a;
        b8     = b;
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        wait_done8(nb, ns);
        chk({tag, "_busy_len"}, nb, 4);
        chk({tag, "_latency"}, ns, 4);
        chk({tag, "_s"}, 32'(s8), 32'(exp_s));
        chk({tag, "_co"}, 32'(co8), 32'(exp_co));
    endtask

    initial begin
        int nb;
        int ns;
        logic [2:0] ref2;

        rst    = 1'b1;
        start8 = 1'b1;
        a8     = 8'hFF;
        b8     = 8'hFF;
        start2 = 1'b1;
        a2     = 2'b11;
        b2     = 2'b11;
        step();
        step();
        // Reset wins over start on the same edge.
        chk("rst_s8", 32'(s8), 0);
        chk("rst_co8", 32'(co8), 0);
        chk("rst_busy8", 32'(busy8), 0);
        chk("rst_done8", 32'(done8), 0);
        chk("rst_s2", 32'(s2), 0);
        chk("rst_busy2", 32'(busy2), 0);
        start8 = 1'b0;
        start2 = 1'b0;
        rst    = 1'b0;
        step();
        chk("idle_busy8", 32'(busy8), 0);

        // Basic add with a look at partial results.
        a8     = 8'h5A;
        b8     = 8'h3C;
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        a8     = 8'h00;
        b8     = 8'h00;
        chk("basic_busy_t0", 32'(busy8), 1);
        chk("basic_s_cleared", 32'(s8), 0);
        step();
        chk("basic_s_slice0", 32'(s8), 'h02);
        step();
        chk("basic_s_slice1", 32'(s8), 'h06);
        step();
        chk("basic_s_slice2", 32'(s8), 'h16);
        chk("basic_busy_t3", 32'(busy8), 1);
        step();
        chk("basic_done", 32'(done8), 1);
        chk("basic_busy_off", 32'(busy8), 0);
        chk("basic_s", 32'(s8), 'h96);
        chk("basic_co", 32'(co8), 0);
        step();
        chk("basic_done_pulse", 32'(done8), 0);
        chk("basic_hold_s", 32'(s8), 'h96);
        chk("basic_hold_busy", 32'(busy8), 0);
        step();
        chk("basic_hold_s2", 32'(s8), 'h96);
        chk("basic_hold_co2", 32'(co8), 0);

        // Carry propagates through every slice.
        op8(8'hFF, 8'h01, "carry_ff_01", 8'h00, 1'b1);
        step();
        op8(8'hFF, 8'hFF, "carry_ff_ff", 8'hFE, 1'b1);
        step();
        op8(8'hA5, 8'h5A, "mix_a5_5a", 8'hFF, 1'b0);
        step();

        // start and operand changes during RUN are ignored.
        a8     = 8'h10;
        b8     = 8'h20;
        start8 = 1'b1;
        step();
        a8     = 8'hFF;
        b8     = 8'hFF;
        wait_done8(nb, ns);
        start8 = 1'b0;
        chk("ign_busy_len", nb, 4);
        chk("ign_s", 32'(s8), 'h30);
        chk("ign_co", 32'(co8), 0);
        step();
        chk("ign_single_done", 32'(done8), 0);
        chk("ign_no_rerun", 32'(busy8), 0);

        // Reset during the second RUN cycle.
        a8     = 8'hAA;
        b8     = 8'h55;
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        step();
        chk("rstmid_partial_s", 32'(s8), 'h03);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstmid_busy", 32'(busy8), 0);
        chk("rstmid_done", 32'(done8), 0);
        chk("rstmid_s", 32'(s8), 0);
        chk("rstmid_co", 32'(co8), 0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rstmid_no_done", 32'(done8), 0);
            chk("rstmid_idle", 32'(busy8), 0);
        end
        op8(8'h01, 8'h02, "rstmid_after", 8'h03, 1'b0);
        step();

        // Back-to-back: new start during the done cycle.
        a8     = 8'h80;
        b8     = 8'h80;
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        wait_done8(nb, ns);
        chk("b2b_first_s", 32'(s8), 'h00);
        chk("b2b_first_co", 32'(co8), 1);
        a8     = 8'h7F;
        b8     = 8'h01;
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        chk("b2b_busy_rise", 32'(busy8), 1);
        chk("b2b_done_drop", 32'(done8), 0);
        chk("b2b_s_cleared", 32'(s8), 0);
        chk("b2b_co_cleared", 32'(co8), 0);
        wait_done8(nb, ns);
        chk("b2b_busy_len", nb, 4);
        chk("b2b_latency", ns + 1, 5);
        chk("b2b_second_s", 32'(s8), 'h80);
        chk("b2b_second_co", 32'(co8), 0);
        step();

        // WIDTH=2 instance, all operand pairs (includes 11 + 01).
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                a2     = 2'(i);
                b2     = 2'(j);
                ref2   = 3'(i + j);
                start2 = 1'b1;
                step();
                start2 = 1'b0;
                chk("w2_busy", 32'(busy2), 1);
                chk("w2_done_low", 32'(done2), 0);
                step();
                chk("w2_done", 32'(done2), 1);
                chk("w2_busy_off", 32'(busy2), 0);
                chk("w2_s", 32'(s2), 32'(ref2[1:0]));
                chk("w2_co", 32'(co2), 32'(ref2[2]));
                step();
                chk("w2_done_pulse", 32'(done2), 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
